uart_tx_arbiter: RTL

//  Shares the single UART transmitter in uart_top between NUM_REQ byte producers.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers
// and latches the line configuration only between frames. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DROP_TO = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      tx_rdy,
    output logic                      tx_load,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      cfg_eight,
    input  logic                      cfg_pen,
    input  logic                      cfg_ohel,
    input  logic [3:0]                cfg_baud,
    output logic                      eight,
    output logic                      pen,
    output logic                      ohel,
    output logic [3:0]                baud,
    output logic                      busy,
    output logic                      err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(DROP_TO + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DROP, WAIT_DONE} state_t;

    state_t            state, state_nx;
    logic              grant, timeout, to_hit;
    logic [IW-1:0]     start, win_c, win_idx;
    logic [DATA_W-1:0] win_data;
    logic [CW-1:0]     to_cnt;
    int                idx;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0] rr_ptr;

    // rr_ptr holds the first index to search, i.e. one past the last grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (state == LOAD)
            rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    end

    assign start = rr_ptr;
`endif

    // Scan farthest-first so the requester closest to start is the last writer
    always_comb begin
        win_c = start;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) win_c = IW'(idx);
        end
    end

    assign to_hit = (to_cnt == CW'(DROP_TO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (tx_rdy && |req) begin
                    grant    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: state_nx = WAIT_DROP;
            WAIT_DROP: begin
                if (!tx_rdy) begin
                    state_nx = WAIT_DONE;
                end else if (to_hit) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: if (tx_rdy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack      <= '0;
            tx_load  <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            eight    <= 1'b0;
            pen      <= 1'b0;
            ohel     <= 1'b0;
            baud     <= 4'd11;
            win_idx  <= '0;
            win_data <= '0;
            to_cnt   <= '0;
        end else begin
            ack     <= '0;
            tx_load <= 1'b0;
            err     <= 1'b0;
            // Config is sampled only while idle so a frame never sees mixed settings
            if (state == IDLE) begin
                eight <= cfg_eight;
                pen   <= cfg_pen;
                ohel  <= cfg_ohel;
                baud  <= cfg_baud;
            end
            if (grant) begin
                win_idx  <= win_c;
                win_data <= req_data[win_c*DATA_W +: DATA_W];
                busy     <= 1'b1;
            end
            if (state == LOAD) begin
                tx_load <= 1'b1;
                tx_data <= win_data;
                ack     <= NUM_REQ'(1) << win_idx;
            end
            to_cnt <= (state == WAIT_DROP) ? to_cnt + CW'(1) : '0;
            if (timeout) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end
            if (state == WAIT_DONE && tx_rdy) busy <= 1'b0;
        end
    end

endmodule
